lector_fifos: RTL and testbench

Output-side reader for the four egress FIFOs that the transaction-layer arbiter fills. Pops the FIFOs round-robin when not empty, absorbs the one-cycle FIFO read latency in a 2-entry output buffer, and presents one valid/ready word stream tagged with its source port. Keeps a saturating per-port word counter that can be read on request. Sits between the egress FIFOs and the downstream consumer of the transaction layer.

---
 rtl/lector_fifos_pkg.sv | 16 +
 rtl/lector_fifos_buffer_salida.sv | 43 ++++
 rtl/lector_fifos.sv | 139 +++++++++++++
 tb/tb_lector_fifos.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lector_fifos_pkg.sv
// Shared constants and state encoding for the egress FIFO reader.
package lector_fifos_pkg;
    localparam int NUM_PORTS  = 4;
    localparam int PORT_IDX_W = 2;
    localparam int BUF_DEPTH  = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    function automatic logic [PORT_IDX_W-1:0] next_port(input logic [PORT_IDX_W-1:0] p);
        return p + 1'b1;
    endfunction
endpackage

// File: rtl/lector_fifos_buffer_salida.sv
// Two-entry output buffer of {src, word}; absorbs the FIFO read latency.
module buffer_salida
    import lector_fifos_pkg::*;
#(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [1:0]   occ,
    output logic [W-1:0] head
);
    logic [W-1:0] r_mem [BUF_DEPTH];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_occ;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BUF_DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (pop) r_rd_ptr <= ~r_rd_ptr;
            // simultaneous push and pop leaves occupancy unchanged
            case ({push, pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign occ  = r_occ;
    assign head = r_mem[r_rd_ptr];
endmodule

// File: rtl/lector_fifos.sv
// Round-robin reader of four egress FIFOs into one tagged valid/ready stream,
// with saturating per-port pop counters readable on request.
module lector_fifos
    import lector_fifos_pkg::*;
#(
    parameter int FIFO_WORD_SIZE = 10,
    parameter int CNT_WIDTH      = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      empty_p0,
    input  logic                      empty_p1,
    input  logic                      empty_p2,
    input  logic                      empty_p3,
    input  logic [FIFO_WORD_SIZE-1:0] data_in_0,
    input  logic [FIFO_WORD_SIZE-1:0] data_in_1,
    input  logic [FIFO_WORD_SIZE-1:0] data_in_2,
    input  logic [FIFO_WORD_SIZE-1:0] data_in_3,
    output logic                      pop_p0,
    output logic                      pop_p1,
    output logic                      pop_p2,
    output logic                      pop_p3,
    output logic [FIFO_WORD_SIZE-1:0] data_out,
    output logic [1:0]                src_out,
    output logic                      valid_out,
    input  logic                      out_ready,
    input  logic                      cnt_req,
    input  logic [1:0]                cnt_idx,
    output logic [CNT_WIDTH-1:0]      cnt_out,
    output logic                      cnt_valid,
    output logic                      idle
);
    logic [FIFO_WORD_SIZE-1:0] w_data_in [NUM_PORTS];
    logic [NUM_PORTS-1:0]      w_empty;
    logic [NUM_PORTS-1:0]      w_pop;
    logic [PORT_IDX_W-1:0]     w_grant;
    logic                      w_found;
    logic                      w_xfer;
    logic                      w_can_pop;
    logic                      w_pop_any;
    logic [2:0]                w_credit_sum;
    logic [1:0]                w_occ;
    logic [PORT_IDX_W+FIFO_WORD_SIZE-1:0] w_head;

    state_t                    r_state;
    logic [PORT_IDX_W-1:0]     r_rr_ptr;
    logic                      r_inflight;
    logic [PORT_IDX_W-1:0]     r_if_src;
    logic [CNT_WIDTH-1:0]      r_cnt [NUM_PORTS];
    logic [CNT_WIDTH-1:0]      r_cnt_out;
    logic                      r_cnt_valid;

    assign w_empty      = {empty_p3, empty_p2, empty_p1, empty_p0};
    assign w_data_in[0] = data_in_0;
    assign w_data_in[1] = data_in_1;
    assign w_data_in[2] = data_in_2;
    assign w_data_in[3] = data_in_3;

    always_comb begin
        w_found = 1'b0;
        w_grant = r_rr_ptr;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!w_found && !w_empty[r_rr_ptr + PORT_IDX_W'(i)]) begin
                w_found = 1'b1;
                w_grant = r_rr_ptr + PORT_IDX_W'(i);
            end
        end
    end

    // Words already owed to the buffer (held + in flight, minus the one leaving)
    // must leave room for the word this pop will return next cycle.
    assign w_xfer       = valid_out && out_ready;
    assign w_credit_sum = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_xfer};
    assign w_can_pop    = enable && !reset && (r_state != ST_DRAIN) && (w_credit_sum < 3'd2);
    assign w_pop_any    = w_can_pop && w_found;
    assign w_pop        = w_pop_any ? (NUM_PORTS'(1) << w_grant) : '0;

    assign {pop_p3, pop_p2, pop_p1, pop_p0} = w_pop;

    buffer_salida #(
        .W(PORT_IDX_W + FIFO_WORD_SIZE)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (r_inflight),
        .push_data ({r_if_src, w_data_in[r_if_src]}),
        .pop       (w_xfer),
        .occ       (w_occ),
        .head      (w_head)
    );

    assign {src_out, data_out} = w_head;
    assign valid_out = (w_occ != 2'd0);
    assign cnt_out   = r_cnt_out;
    assign cnt_valid = r_cnt_valid;
    assign idle      = (r_state == ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_inflight  <= 1'b0;
            r_if_src    <= '0;
            r_cnt_out   <= '0;
            r_cnt_valid <= 1'b0;
            for (int i = 0; i < NUM_PORTS; i++) r_cnt[i] <= '0;
        end else begin
            r_inflight <= w_pop_any;
            if (w_pop_any) begin
                r_if_src <= w_grant;
                r_rr_ptr <= next_port(w_grant);
                if (r_cnt[w_grant] != '1) r_cnt[w_grant] <= r_cnt[w_grant] + 1'b1;
            end

            r_cnt_valid <= cnt_req;
            if (cnt_req) r_cnt_out <= r_cnt[cnt_idx];

            case (r_state)
                ST_IDLE: begin
                    if (w_pop_any) r_state <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (!enable && ((w_occ != 2'd0) || r_inflight))
                        r_state <= ST_DRAIN;
                    else if ((w_occ == 2'd0) && !r_inflight && !w_pop_any)
                        r_state <= ST_IDLE;
                end
                ST_DRAIN: begin
                    if (enable)
                        r_state <= ST_ACTIVE;
                    else if ((w_occ == 2'd0) && !r_inflight)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lector_fifos.sv
// Directed bench for lector_fifos: queue-modelled egress FIFOs feed a scoreboard
// that is checked against every accepted output word.
module tb_lector_fifos;
    logic       clk;
    logic       reset;
    logic       enable;
    logic [3:0] emp;
    logic [9:0] din [4];
    logic       pop_p0, pop_p1, pop_p2, pop_p3;
    logic [9:0] data_out;
    logic [1:0] src_out;
    logic       valid_out;
    logic       out_ready;
    logic       cnt_req;
    logic [1:0] cnt_idx;
    logic [4:0] cnt_out;
    logic       cnt_valid;
    logic       idle;
    logic [3:0] pops;

    logic [9:0]  fq [4][$];
    logic [11:0] sb [$];
    int          pop_log [$];
    int          pop_cyc [$];
    int          total, bad, cyc;

    lector_fifos #(.FIFO_WORD_SIZE(10), .CNT_WIDTH(5)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .empty_p0(emp[0]), .empty_p1(emp[1]), .empty_p2(emp[2]), .empty_p3(emp[3]),
        .data_in_0(din[0]), .data_in_1(din[1]), .data_in_2(din[2]), .data_in_3(din[3]),
        .pop_p0(pop_p0), .pop_p1(pop_p1), .pop_p2(pop_p2), .pop_p3(pop_p3),
        .data_out(data_out), .src_out(src_out), .valid_out(valid_out), .out_ready(out_ready),
        .cnt_req(cnt_req), .cnt_idx(cnt_idx), .cnt_out(cnt_out), .cnt_valid(cnt_valid),
        .idle(idle)
    );

    assign pops = {pop_p3, pop_p2, pop_p1, pop_p0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge, model the FIFOs, update inputs just after posedge.
    task automatic step();
        int         g;
        int         np;
        logic [9:0] w;
        logic [11:0] e;
        logic       popped;
        popped = 1'b0;
        g = 0;
        w = '0;
        @(negedge clk);
        np = 0;
        for (int p = 0; p < 4; p++) if (pops[p]) begin np++; g = p; end
        chk("pop_onehot", np <= 1, 1);
        if (valid_out && out_ready) begin
            chk("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("src_out", src_out, e[11:10]);
                chk("data_out", data_out, e[9:0]);
            end
        end
        if (np != 0) begin
            chk("pop_nonempty", fq[g].size() != 0, 1);
            if (fq[g].size() != 0) begin
                w = fq[g].pop_front();
                popped = 1'b1;
                sb.push_back({g[1:0], w});
                pop_log.push_back(g);
                pop_cyc.push_back(cyc);
            end
        end
        @(posedge clk);
        #1;
        if (popped) din[g] = w;
        for (int p = 0; p < 4; p++) emp[p] = (fq[p].size() == 0);
        cyc++;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step();
        step();
        sb.delete();
        pop_log.delete();
        pop_cyc.delete();
        for (int p = 0; p < 4; p++) begin
            fq[p].delete();
            emp[p] = 1'b1;
        end
        reset = 1'b0;
    endtask

    task automatic drain(input int maxc);
        int n;
        n = 0;
        while (!(sb.size() == 0 && idle === 1'b1 && fq[0].size() == 0 && fq[1].size() == 0 &&
                 fq[2].size() == 0 && fq[3].size() == 0) && n < maxc) begin
            step();
            n++;
        end
        chk("drain_timeout", n < maxc, 1);
    endtask

    task automatic read_cnt(input logic [1:0] idx, input logic [4:0] exp);
        cnt_req = 1'b1;
        cnt_idx = idx;
        step();
        cnt_req = 1'b0;
        chk("cnt_valid", cnt_valid, 1);
        chk("cnt_out", cnt_out, exp);
        step();
        chk("cnt_valid_pulse", cnt_valid, 0);
        chk("cnt_out_hold", cnt_out, exp);
    endtask

    initial begin
        int base;
        int n;
        total = 0; bad = 0; cyc = 0;
        reset = 1'b1; enable = 1'b0; out_ready = 1'b0; cnt_req = 1'b0; cnt_idx = 2'd0;
        emp = 4'hF;
        for (int p = 0; p < 4; p++) din[p] = '0;

        // reset state
        step();
        step();
        chk("rst_idle", idle, 1);
        chk("rst_valid", valid_out, 0);
        chk("rst_data", data_out, 0);
        chk("rst_src", src_out, 0);
        chk("rst_cnt_out", cnt_out, 0);
        chk("rst_cnt_valid", cnt_valid, 0);
        chk("rst_pops", pops, 0);
        reset = 1'b0;

        // single port p2, three words, streaming consumer
        enable = 1'b1; out_ready = 1'b1;
        fq[2].push_back(10'h2A1); fq[2].push_back(10'h2A2); fq[2].push_back(10'h2A3);
        drain(30);
        chk("p2_pop_count", pop_log.size(), 3);
        for (int i = 0; i < pop_log.size(); i++) chk("p2_port", pop_log[i], 2);
        if (pop_cyc.size() == 3) chk("p2_consecutive", pop_cyc[2] - pop_cyc[0], 2);
        chk("p2_idle", idle, 1);
        read_cnt(2'd2, 5'd3);

        // all four ports: round-robin, one pop per cycle
        apply_reset();
        enable = 1'b1; out_ready = 1'b1;
        for (int p = 0; p < 4; p++) begin
            fq[p].push_back(10'(10'h100 + p));
            fq[p].push_back(10'(10'h180 + p));
        end
        drain(40);
        chk("rr_pop_count", pop_log.size(), 8);
        for (int i = 0; i < pop_log.size(); i++) begin
            chk("rr_order", pop_log[i], i % 4);
            chk("rr_back_to_back", pop_cyc[i] - pop_cyc[0], i);
        end

        // stalled consumer: at most two outstanding, head held stable
        apply_reset();
        enable = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) fq[1].push_back(10'(10'h110 + i));
        repeat (6) step();
        chk("stall_pops", pop_log.size(), 2);
        chk("stall_valid", valid_out, 1);
        chk("stall_data", data_out, 10'h110);
        chk("stall_src", src_out, 1);
        repeat (3) step();
        chk("stall_pops_hold", pop_log.size(), 2);
        chk("stall_data_hold", data_out, 10'h110);
        out_ready = 1'b1;
        drain(30);
        chk("stall_resume_pops", pop_log.size(), 4);

        // enable drops the cycle after a pop: in-flight word still delivered
        apply_reset();
        enable = 1'b1; out_ready = 1'b1;
        fq[0].push_back(10'h0C1); fq[0].push_back(10'h0C2); fq[0].push_back(10'h0C3);
        step();
        n = 0;
        while (pop_log.size() == 0 && n < 5) begin step(); n++; end
        chk("en_first_pop", pop_log.size(), 1);
        enable = 1'b0;
        step();
        chk("en_drain_not_idle", idle, 0);
        chk("en_drain_valid", valid_out, 1);
        chk("en_drain_data", data_out, 10'h0C1);
        repeat (6) step();
        chk("en_no_more_pops", pop_log.size(), 1);
        chk("en_idle", idle, 1);
        chk("en_delivered", sb.size(), 0);

        // saturation and pre-increment counter read
        apply_reset();
        enable = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 40; i++) fq[3].push_back(10'(i));
        drain(100);
        chk("sat_pops", pop_log.size(), 40);
        read_cnt(2'd3, 5'd31);
        fq[0].push_back(10'h155);
        step();
        base = pop_log.size();
        cnt_req = 1'b1; cnt_idx = 2'd0;
        step();
        cnt_req = 1'b0;
        chk("pre_inc_pop_seen", pop_log.size(), base + 1);
        if (pop_log.size() == base + 1) chk("pre_inc_pop_port", pop_log[base], 0);
        chk("pre_inc_valid", cnt_valid, 1);
        chk("pre_inc_value", cnt_out, 0);
        drain(20);
        read_cnt(2'd0, 5'd1);

        // reset with buffered and in-flight words
        apply_reset();
        enable = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) fq[1].push_back(10'(10'h1E0 + i));
        n = 0;
        while (pop_log.size() < 2 && n < 10) begin step(); n++; end
        chk("rst_mid_pops", pop_log.size(), 2);
        chk("rst_mid_valid_before", valid_out, 1);
        reset = 1'b1;
        step();
        chk("rst_mid_valid", valid_out, 0);
        chk("rst_mid_idle", idle, 1);
        chk("rst_mid_data", data_out, 0);
        chk("rst_mid_pops_low", pops, 0);
        step();
        reset = 1'b0;
        sb.delete();
        enable = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rst_no_stale", valid_out, 0);
        end
        read_cnt(2'd1, 5'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
